// File: rtl/multdiv_seq.sv
// ============================================================================
// Module   : multdiv_seq
// Brief    : Control sequencer for an iterative radix-2 32-bit multiply/divide
//            unit: start/step/done handshake, register strobes, exception flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_seq #(
    parameter int STEPS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    input  logic             mult_ovf,
    output logic             op_latch_en,
    output logic             acc_clr,
    output logic             step_en,
    output logic             is_div,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             result_ready,
    output logic             result_exception
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] c_STEP_ONE  = CNT_W'(1);

    state_t           r_state;
    logic             r_is_div;
    logic [CNT_W-1:0] r_step_idx;
    logic             r_exc;
    logic             w_start;

    // Both start pulses together is illegal and behaves as no start at all.
    assign w_start = ctrl_mult ^ ctrl_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_step_idx <= '0;
            r_exc      <= 1'b0;
        end else if (w_start) begin
            // A new start wins in every state, aborting any in-flight operation.
            r_state    <= S_LOAD;
            r_is_div   <= ctrl_div;
            r_step_idx <= '0;
            r_exc      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (r_is_div && divisor_zero) begin
                        r_state <= S_DONE;
                        r_exc   <= 1'b1;
                    end else begin
                        r_state    <= S_RUN;
                        r_step_idx <= '0;
                    end
                end
                S_RUN: begin
                    if (r_step_idx == c_LAST_STEP) begin
                        r_state    <= S_DONE;
                        r_step_idx <= '0;
                        if (!r_is_div) begin
                            r_exc <= mult_ovf;
                        end
                    end else begin
                        r_step_idx <= r_step_idx + c_STEP_ONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign op_latch_en      = w_start;
    assign acc_clr          = (r_state == S_LOAD);
    assign step_en          = (r_state == S_RUN);
    assign busy             = (r_state == S_LOAD) || (r_state == S_RUN);
    assign result_ready     = (r_state == S_DONE);
    assign result_exception = (r_state == S_DONE) && r_exc;
    assign is_div           = r_is_div;
    assign step_idx         = r_step_idx;

endmodule

`default_nettype wire

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Control sequencer for the processor's iterative 32-bit multiply/divide unit.
- Owns the start/step/done handshake with the core.
- Drives the enable and clear strobes of the unit's operand, accumulator and quotient registers; these are 32-bit enable registers with async clear.
- Decides when results are valid and when an exception is flagged. Contains no arithmetic datapath itself.

Parameters:
STEPS, 32, number of iteration cycles per operation (one bit per cycle, radix-2)
CNT_W, 6, width of step counter; must satisfy 2^CNT_W > STEPS

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
ctrl_mult  input  1  single-cycle start pulse for multiply
ctrl_div  input  1  single-cycle start pulse for divide
divisor_zero  input  1  datapath flag, valid while state=LOAD
mult_ovf  input  1  datapath overflow flag, valid during last RUN cycle
op_latch_en  output  1  enable for operand registers (combinational)
acc_clr  output  1  clear strobe for accumulator/quotient registers
step_en  output  1  enable for one shift/add-sub iteration
is_div  output  1  current operation is divide (0 = multiply)
step_idx  output  CNT_W  current iteration index
busy  output  1  operation in progress
result_ready  output  1  one-cycle result-valid pulse
result_exception  output  1  exception qualifier, valid only with result_ready

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Registered state; all outputs except op_latch_en decode from state and registers.
- Reset (async, any time, including mid-operation):
  - State goes to IDLE immediately.
  - is_div=0, step_idx=0, exception register=0.
  - All outputs 0. In-flight operation is discarded with no result_ready.
- Start:
  - Valid start is ctrl_mult XOR ctrl_div sampled high at a rising edge.
  - Both high in the same cycle is illegal: ignored, with no state change and op_latch_en=0.
  - op_latch_en = ctrl_mult XOR ctrl_div, combinationally and in every state, so operands are captured on the same edge that accepts the start.
  - On a valid start, from any state: next state LOAD, is_div<=ctrl_div, step_idx<=0, exception register cleared.
  - A start during LOAD or RUN aborts the current operation and restarts. No result_ready is produced for the aborted operation.
  - A start during DONE is accepted; the result_ready pulse of that DONE cycle still occurs.
- LOAD (exactly 1 cycle):
  - acc_clr=1, busy=1.
  - If is_div and divisor_zero: next state DONE, exception register<=1.
  - Otherwise: next state RUN, step_idx=0.
- RUN:
  - step_en=1, busy=1. step_idx holds the index of the iteration being performed this cycle.
  - step_idx increments by 1 each cycle.
  - On the cycle with step_idx==STEPS-1:
    - exception register<=mult_ovf if not is_div, else unchanged (0).
    - Next state DONE. step_idx wraps to 0.
  - Exactly STEPS cycles of step_en per non-exceptional operation.
- DONE (exactly 1 cycle):
  - result_ready=1, result_exception=exception register, busy=0, step_en=0, acc_clr=0.
  - Next state IDLE unless a valid start is present (then LOAD).
- IDLE:
  - All outputs 0 except op_latch_en.
  - is_div and step_idx retain their last values; step_idx is 0 after a completed run.
- Latency, with the start sampled at edge E0:
  - LOAD during E0..E1.
  - RUN steps 0..STEPS-1 occupy E1..E(STEPS+1).
  - result_ready is high between E(STEPS+1) and E(STEPS+2): 33 cycles after start for STEPS=32.
  - Divide-by-zero: result_ready high between E1 and E2.
- result_exception is 0 whenever result_ready is 0.

Test Plan:
- Reset then multiply:
  - Stimulus: hold rst 3 cycles, release, pulse ctrl_mult for 1 cycle with mult_ovf=0.
  - op_latch_en=1 in the pulse cycle; acc_clr for 1 cycle; step_en for exactly 32 cycles with step_idx 0..31.
  - result_ready for 1 cycle at start+33 with result_exception=0, is_div=0; busy high 33 cycles.
- Divide by zero: pulse ctrl_div with divisor_zero=1 during LOAD -> no step_en, result_ready=1 and result_exception=1 at start+1, then IDLE.
- Multiply overflow: pulse ctrl_mult, drive mult_ovf=1 only on the step_idx=31 cycle -> result_ready with result_exception=1; mult_ovf=1 on step_idx=10 only -> result_exception=0.
- Restart mid-run:
  - Stimulus: pulse ctrl_div, then pulse ctrl_mult when step_idx=12.
  - Required: no result_ready for the divide; new LOAD with is_div=0; full 32 steps; a single result_ready 33 cycles after the second pulse.
- Async reset mid-operation: assert rst between clock edges at step_idx=20 -> busy, step_en, step_idx all 0 before the next edge; no result_ready afterwards.
- Simultaneous and back-to-back starts:
  - ctrl_mult and ctrl_div high together in IDLE -> op_latch_en=0, stays IDLE.
  - Start pulse during the DONE cycle -> result_ready still 1 that cycle, LOAD on the next cycle.
